tlc_bus_arbiter: RTL and testbench
==================================

// Module: tlc_bus_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares the traffic-light controller register bus
//  (pvalid/paddr/pwdata/prd_wr -> pready/prdata) between NREQ requesters (host CPU,
//  emergency override, maintenance port, ...). Issues one single-beat access at a time,
//  holds it until pready, returns read data and a done pulse, and aborts hung accesses on timeout.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  AW       8   register address width
//  DW       32  data width
//  TIMEOUT  15  max cycles in ACCESS waiting for pready; 0 = timeout disabled
// PORTS
//  pclk       in   1        clock, all logic on rising edge
//  prst       in   1        asynchronous, active-high reset
//  req_valid  in   NREQ     per-requester request; held high until own req_done
//  req_wr     in   NREQ     per-requester direction: 1 = write, 0 = read
//  req_addr   in   NREQ*AW  flattened addresses; requester i uses [i*AW +: AW]
//  req_wdata  in   NREQ*DW  flattened write data; requester i uses [i*DW +: DW]
//  req_done   out  NREQ     one-cycle pulse to the granted requester at completion or abort
//  req_err    out  1        one-cycle pulse coincident with req_done on timeout abort
//  req_rdata  out  DW       read data, valid in the req_done cycle of a read, held after
//  busy       out  1        high in ACCESS and RECOVER
//  pvalid     out  1        access valid to controller
//  prd_wr     out  1        1 = write, 0 = read
//  paddr      out  AW       access address
//  pwdata     out  DW       write data
//  pready     in   1        controller acknowledge; prdata valid when high
//  prdata     in   DW       controller read data
// BEHAVIOUR
//  Reset: every output 0, FSM = IDLE, rr pointer = 0, timeout counter = 0; applies instantly,
//   including mid-access (pvalid drops with no done pulse; the requester must re-issue).
//  FSM IDLE -> ACCESS -> RECOVER -> IDLE.
//   IDLE: if any req_valid, grant the first set bit searching from rr pointer upward with
//    wrap (ptr, ptr+1, ..., NREQ-1, 0, ...). On that edge latch grant index, prd_wr, paddr,
//    pwdata from the winner; pvalid=1; next state ACCESS. No request: stay, pvalid=0.
//   ACCESS: pvalid, paddr, pwdata, prd_wr held constant. On edge with pready=1: req_done[g]=1,
//    req_rdata<=prdata if read (unchanged on write), pvalid=0, rr pointer<=(g+1) mod NREQ,
//    next state RECOVER.
//    Timeout: counter is 0 on entry, +1 per ACCESS edge with pready=0. Edge with counter==TIMEOUT
//    and pready=0 (TIMEOUT>0): req_done[g]=1, req_err=1, req_rdata unchanged, pvalid=0, pointer
//    advances as on success, next state RECOVER. pready=1 on that same edge wins: normal completion.
//   RECOVER: pvalid=0 for exactly one cycle so controller drops pready; then IDLE.
//  Latency, controller acking one cycle after pvalid: req_valid seen at edge E0, pvalid high after
//   E0, pready high after E1, req_done/req_rdata after E2, IDLE after E3, next grant at E4.
//   Back-to-back throughput is one access per 4 cycles.
//  Grant is registered: req_valid/addr/data changes after grant do not affect the current access.
//   A requester dropping req_valid mid-access still receives req_done.
//  Requests arriving in ACCESS/RECOVER wait for IDLE arbitration; none are lost if held.
//  req_done is never set for more than one bit; req_err never high without req_done.
//  Counter width $clog2(TIMEOUT+1); no wrap (leaves ACCESS at TIMEOUT).
// TESTING
//  1 Req0 writes addr 8'h0C data 32'h3 -> pvalid,prd_wr=1,paddr=0C one cycle after req;
//    req_done[0] two cycles later; controller mode register reads back 3.
//  2 Req2 reads 8'h00 after red time programmed to 32'h0005_000A -> req_rdata=32'h0005_000A
//    in req_done[2] cycle; req_err=0.
//  3 All four req_valid held high, 8 accesses -> grant order 0,1,2,3,0,1,2,3; one per 4 cycles.
//  4 Stub pready tied 0, TIMEOUT=15 -> pvalid high 16 cycles, then req_done[g]=1 with
//    req_err=1, one RECOVER cycle, next requester granted.
//  5 Assert prst in ACCESS cycle -> pvalid, req_done, busy 0 at once; after release, held
//    request regranted starting from requester 0.
//  6 Req1 drops req_valid and changes req_addr after grant -> paddr unchanged; req_done[1] still pulses.

Source files
------------

// File: rtl/tlc_bus_arbiter.sv
// Round-robin sequencer sharing the traffic-light controller register bus between NREQ requesters.
// Latency: grant on the edge a request is seen in IDLE; req_done on the edge pready is sampled; 4 cycles/access.
// Backpressure: requests hold req_valid until their own req_done; hung accesses abort after TIMEOUT cycles.
module tlc_bus_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                 pclk,
   input  logic                 prst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_wr,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_wdata,
   output logic [NREQ-1:0]      req_done,
   output logic                 req_err,
   output logic [DW-1:0]        req_rdata,
   output logic                 busy,
   output logic                 pvalid,
   output logic                 prd_wr,
   output logic [AW-1:0]        paddr,
   output logic [DW-1:0]        pwdata,
   input  logic                 pready,
   input  logic [DW-1:0]        prdata
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACCESS  = 2'd1;
   localparam logic [1:0] ST_RECOVER = 2'd2;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } acc_t;

   logic [1:0]    state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] nxt_ptr;
   logic          win_vld;
   logic [CW-1:0] to_cnt;
   logic          to_hit;
   acc_t          win_acc;

   // First requester at or above rr_ptr, wrapping back to 0.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_vld && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
            win_vld = 1'b1;
            win_idx = IW'((int'(rr_ptr) + k) % NREQ);
         end
      end
   end

   always_comb begin
      win_acc.wr    = req_wr[win_idx];
      win_acc.addr  = req_addr[win_idx*AW +: AW];
      win_acc.wdata = req_wdata[win_idx*DW +: DW];
   end

   assign nxt_ptr = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
   assign to_hit  = (TIMEOUT != 0) && (to_cnt == CW'(TIMEOUT));

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         gnt_idx   <= '0;
         to_cnt    <= '0;
         req_done  <= '0;
         req_err   <= 1'b0;
         req_rdata <= '0;
         busy      <= 1'b0;
         pvalid    <= 1'b0;
         prd_wr    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
      end else begin
         req_done <= '0;
         req_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  gnt_idx <= win_idx;
                  prd_wr  <= win_acc.wr;
                  paddr   <= win_acc.addr;
                  pwdata  <= win_acc.wdata;
                  pvalid  <= 1'b1;
                  busy    <= 1'b1;
                  to_cnt  <= '0;
                  state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // A late pready on the timeout edge still counts as a normal completion.
               if (pready) begin
                  req_done[gnt_idx] <= 1'b1;
                  if (!prd_wr)
                     req_rdata <= prdata;
                  pvalid <= 1'b0;
                  rr_ptr <= nxt_ptr;
                  state  <= ST_RECOVER;
               end else if (to_hit) begin
                  req_done[gnt_idx] <= 1'b1;
                  req_err           <= 1'b1;
                  pvalid            <= 1'b0;
                  rr_ptr            <= nxt_ptr;
                  state             <= ST_RECOVER;
               end else if (TIMEOUT != 0) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ST_RECOVER: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy   <= 1'b0;
               pvalid <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlc_bus_arbiter.sv
// Directed bench for tlc_bus_arbiter with a register-file controller stub that acks one cycle after pvalid.
module tb_tlc_bus_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 8;
   localparam int DW   = 32;

   logic              pclk;
   logic              prst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_wr;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]   req_done;
   logic              req_err;
   logic [DW-1:0]     req_rdata;
   logic              busy;
   logic              pvalid;
   logic              prd_wr;
   logic [AW-1:0]     paddr;
   logic [DW-1:0]     pwdata;
   logic              pready;
   logic [DW-1:0]     prdata;

   logic              stub_en;
   logic [31:0]       regs [0:255];

   int n_tests;
   int n_fail;

   tlc_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(15)) dut (
      .pclk      (pclk),
      .prst      (prst),
      .req_valid (req_valid),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_done  (req_done),
      .req_err   (req_err),
      .req_rdata (req_rdata),
      .busy      (busy),
      .pvalid    (pvalid),
      .prd_wr    (prd_wr),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pready    (pready),
      .prdata    (prdata)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   // Controller stub: register file preloaded with A000_0000 | addr, acks one cycle after pvalid.
   always @(posedge pclk or posedge prst) begin
      if (prst) begin
         pready <= 1'b0;
         prdata <= '0;
         for (int a = 0; a < 256; a++)
            regs[a] <= 32'hA000_0000 | 32'(a);
      end else begin
         pready <= stub_en && pvalid && !pready;
         if (stub_en && pvalid && !pready) begin
            if (prd_wr)
               regs[paddr] <= pwdata;
            prdata <= regs[paddr];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic wr, input logic [7:0] a, input logic [31:0] d);
      req_valid[i]          = v;
      req_wr[i]             = wr;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic wait_done(input string tag, input int i, input logic exp_err, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (req_done == '0 && cyc < 40);
      check(tag, 32'(req_done), 32'(1) << i);
      check({tag, " err"}, 32'(req_err), 32'(exp_err));
   endtask

   task automatic wait_grant(input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!pvalid && n < 20);
      check(tag, 32'(pvalid), 32'd1);
   endtask

   task automatic do_reset();
      prst = 1'b1;
      tick();
      tick();
      prst = 1'b0;
   endtask

   initial begin
      int cyc;
      int k;
      int last;
      int hi_cnt;
      n_tests   = 0;
      n_fail    = 0;
      stub_en   = 1'b1;
      req_valid = '0;
      req_wr    = '0;
      req_addr  = '0;
      req_wdata = '0;
      prst      = 1'b1;
      tick();
      tick();
      check("rst pvalid", 32'(pvalid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(req_done), 32'd0);
      check("rst err", 32'(req_err), 32'd0);
      check("rst rdata", req_rdata, 32'd0);
      prst = 1'b0;

      // 1: write mode register, exact cycle timing
      set_req(0, 1'b1, 1'b1, 8'h0C, 32'h3);
      tick();
      check("t1 pvalid", 32'(pvalid), 32'd1);
      check("t1 prd_wr", 32'(prd_wr), 32'd1);
      check("t1 paddr", 32'(paddr), 32'h0C);
      check("t1 pwdata", pwdata, 32'h3);
      check("t1 busy", 32'(busy), 32'd1);
      tick();
      check("t1 no early done", 32'(req_done), 32'd0);
      check("t1 pvalid held", 32'(pvalid), 32'd1);
      tick();
      check("t1 done", 32'(req_done), 32'b0001);
      check("t1 err", 32'(req_err), 32'd0);
      check("t1 pvalid drop", 32'(pvalid), 32'd0);
      check("t1 busy recover", 32'(busy), 32'd1);
      set_req(0, 1'b0, 1'b0, 8'h0C, 32'h0);
      tick();
      check("t1 idle busy", 32'(busy), 32'd0);
      check("t1 idle done", 32'(req_done), 32'd0);
      set_req(0, 1'b1, 1'b0, 8'h0C, 32'h0);
      wait_done("t1 rd done", 0, 1'b0, cyc);
      check("t1 rd latency", 32'(cyc), 32'd3);
      check("t1 rd data", req_rdata, 32'h3);
      set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);

      // 2: program red time then read it back via requester 2
      set_req(2, 1'b1, 1'b1, 8'h00, 32'h0005_000A);
      wait_done("t2 wr done", 2, 1'b0, cyc);
      set_req(2, 1'b1, 1'b0, 8'h00, 32'h0);
      wait_done("t2 rd done", 2, 1'b0, cyc);
      check("t2 rd data", req_rdata, 32'h0005_000A);
      set_req(2, 1'b0, 1'b0, 8'h00, 32'h0);

      // 3: all requesters held, round-robin order and 4-cycle throughput
      do_reset();
      for (int i = 0; i < NREQ; i++)
         set_req(i, 1'b1, 1'b0, 8'h10 + 8'(i), 32'h0);
      k = 0;
      last = 0;
      cyc = 0;
      while (k < 8 && cyc < 60) begin
         tick();
         cyc++;
         if (req_done != '0) begin
            check("t3 grant", 32'(req_done), 32'(1) << (k % 4));
            check("t3 rdata", req_rdata, 32'hA000_0010 + 32'(k % 4));
            if (k == 0)
               check("t3 first latency", 32'(cyc), 32'd3);
            else
               check("t3 spacing", 32'(cyc - last), 32'd4);
            last = cyc;
            k++;
         end
      end
      check("t3 count", 32'(k), 32'd8);
      req_valid = '0;

      // 4: hung controller, timeout abort then next requester
      stub_en = 1'b0;
      set_req(1, 1'b1, 1'b0, 8'h21, 32'h0);
      set_req(2, 1'b1, 1'b0, 8'h22, 32'h0);
      wait_grant("t4 grant");
      check("t4 gnt addr", 32'(paddr), 32'h21);
      hi_cnt = 0;
      cyc = 0;
      while (req_done == '0 && cyc < 40) begin
         if (pvalid)
            hi_cnt++;
         tick();
         cyc++;
      end
      check("t4 pvalid cycles", 32'(hi_cnt), 32'd16);
      check("t4 done", 32'(req_done), 32'b0010);
      check("t4 err", 32'(req_err), 32'd1);
      check("t4 rdata kept", req_rdata, 32'hA000_0013);
      check("t4 busy recover", 32'(busy), 32'd1);
      set_req(1, 1'b0, 1'b0, 8'h21, 32'h0);
      tick();
      check("t4 recover pvalid", 32'(pvalid), 32'd0);
      check("t4 idle busy", 32'(busy), 32'd0);
      check("t4 err pulse", 32'(req_err), 32'd0);
      tick();
      check("t4 next pvalid", 32'(pvalid), 32'd1);
      check("t4 next addr", 32'(paddr), 32'h22);
      stub_en = 1'b1;
      wait_done("t4 next done", 2, 1'b0, cyc);
      check("t4 next data", req_rdata, 32'hA000_0022);
      set_req(2, 1'b0, 1'b0, 8'h22, 32'h0);

      // 5: reset mid-access, pointer returns to 0
      stub_en = 1'b0;
      set_req(1, 1'b1, 1'b0, 8'h31, 32'h0);
      set_req(3, 1'b1, 1'b0, 8'h33, 32'h0);
      wait_grant("t5 grant");
      check("t5 gnt addr", 32'(paddr), 32'h33);
      tick();
      prst = 1'b1;
      #1;
      check("t5 rst pvalid", 32'(pvalid), 32'd0);
      check("t5 rst busy", 32'(busy), 32'd0);
      check("t5 rst done", 32'(req_done), 32'd0);
      tick();
      prst = 1'b0;
      stub_en = 1'b1;
      tick();
      check("t5 regrant pvalid", 32'(pvalid), 32'd1);
      check("t5 regrant addr", 32'(paddr), 32'h31);
      wait_done("t5 done1", 1, 1'b0, cyc);
      set_req(1, 1'b0, 1'b0, 8'h31, 32'h0);
      wait_done("t5 done3", 3, 1'b0, cyc);
      check("t5 data3", req_rdata, 32'hA000_0033);
      set_req(3, 1'b0, 1'b0, 8'h33, 32'h0);

      // 6: request dropped and address changed after grant
      set_req(1, 1'b1, 1'b0, 8'h10, 32'h0);
      wait_grant("t6 grant");
      set_req(1, 1'b0, 1'b1, 8'h55, 32'hDEAD_BEEF);
      tick();
      check("t6 paddr held", 32'(paddr), 32'h10);
      check("t6 prd_wr held", 32'(prd_wr), 32'd0);
      wait_done("t6 done", 1, 1'b0, cyc);
      check("t6 data", req_rdata, 32'hA000_0010);
      tick();
      tick();
      tick();
      check("t6 no regrant", 32'(pvalid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
